// File: rtl/acc_sp_unit.sv
// acc_sp_unit
// -----------------------------------------------------------------------------
// Accumulator and stack-pointer register unit for the accumulator datapath.
// Builds the immediate forms (sign-extended, sign-extended << 1, zero-extended,
// upper-placed), selects and registers the accumulator source, and owns a
// stack pointer that pushes/pops by STEP without an ALU pass.
//
// Optional feature macro: ACC_SP_BOUNDS_CHECK_EN
//   defined   : push/pop are refused at the stack bounds and raise sticky
//               SpOverflow / SpUnderflow flags (cleared by FaultClr).
//   undefined : push/pop always adjust SP modulo 2^DW, flags tied 0,
//               FaultClr ignored.
//
// Ports:
//   CLK         in   1   clock, rising edge
//   reset       in   1   synchronous, active-high
//   IR          in   IW  immediate field
//   MemData     in   DW  memory read data
//   MDR         in   DW  memory data register
//   ALU         in   DW  ALU result
//   AccSrc      in   3   accumulator source select
//   AccWrite    in   1   accumulator write enable
//   SpOp        in   2   00 hold, 01 push, 10 pop, 11 load from ALU
//   FaultClr    in   1   clears sticky fault flags
//   AccOutput   out  DW  accumulator register
//   SpOutput    out  DW  stack-pointer register
//   SE          out  DW  sign-extended IR
//   SELeft      out  DW  SE << 1, truncated
//   ZE          out  DW  zero-extended IR
//   StackEmpty  out  1   SP == SP_INIT
//   StackFull   out  1   SP - STEP < SP_LIMIT (DW+1 bits wide)
//   SpOverflow  out  1   sticky: push refused
//   SpUnderflow out  1   sticky: pop refused
// -----------------------------------------------------------------------------
module acc_sp_unit #(
    parameter int unsigned     DW       = 16,
    parameter int unsigned     IW       = 8,
    parameter logic [DW-1:0]   SP_INIT  = 16'h0400,
    parameter logic [DW-1:0]   SP_LIMIT = 16'h03F0,
    parameter int unsigned     STEP     = 2
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [IW-1:0] IR,
    input  logic [DW-1:0] MemData,
    input  logic [DW-1:0] MDR,
    input  logic [DW-1:0] ALU,
    input  logic [2:0]    AccSrc,
    input  logic          AccWrite,
    input  logic [1:0]    SpOp,
    input  logic          FaultClr,
    output logic [DW-1:0] AccOutput,
    output logic [DW-1:0] SpOutput,
    output logic [DW-1:0] SE,
    output logic [DW-1:0] SELeft,
    output logic [DW-1:0] ZE,
    output logic          StackEmpty,
    output logic          StackFull,
    output logic          SpOverflow,
    output logic          SpUnderflow
);

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_PUSH = 2'b01;
    localparam logic [1:0] SP_POP  = 2'b10;
    localparam logic [1:0] SP_LOAD = 2'b11;

    function automatic logic signed [DW-1:0] signExtend(input logic [IW-1:0] v);
        logic signed [DW-1:0] r;
        r = {{(DW-IW){v[IW-1]}}, v};
        return r;
    endfunction

    function automatic logic [DW-1:0] zeroExtend(input logic [IW-1:0] v);
        return {{(DW-IW){1'b0}}, v};
    endfunction

    // Immediate forms (combinational)
    logic signed [DW-1:0] seSigned;

    assign seSigned = signExtend(IR);
    assign SE       = seSigned;
    assign SELeft   = {seSigned[DW-2:0], 1'b0};
    assign ZE       = zeroExtend(IR);

    // Accumulator source select
    logic [DW-1:0] accNext;

    always_comb begin
        accNext = AccOutput;
        case (AccSrc)
            3'd0:    accNext = {IR, {(DW-IW){1'b0}}};
            3'd1:    accNext = MDR;
            3'd2:    accNext = MemData;
            3'd3:    accNext = SE;
            3'd4:    accNext = ALU;
            3'd5:    accNext = ZE;
            // Lower fill: keeps the upper immediate loaded by source 0.
            3'd6:    accNext = {AccOutput[DW-1:IW], IR};
            default: accNext = AccOutput;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            AccOutput <= '0;
        end else if (AccWrite) begin
            AccOutput <= accNext;
        end
    end

    // Stack bounds, one extra bit so a borrow/carry is visible
    logic [DW:0] spWide;
    logic [DW:0] stepWide;
    logic [DW:0] limitWide;
    logic [DW:0] spDec;
    logic [DW:0] spInc;

    assign spWide    = {1'b0, SpOutput};
    assign stepWide  = (DW+1)'(STEP);
    assign limitWide = {1'b0, SP_LIMIT};
    assign spDec     = spWide - stepWide;
    assign spInc     = spWide + stepWide;

    // A borrow out of the subtraction means SP is already below STEP.
    assign StackFull  = spDec[DW] | (spDec < limitWide);
    assign StackEmpty = (SpOutput == SP_INIT);

    logic [DW-1:0] spNext;

`ifdef ACC_SP_BOUNDS_CHECK_EN
    logic [DW:0] initWide;
    logic        popOk;
    logic        ovfNext;
    logic        udfNext;

    assign initWide = {1'b0, SP_INIT};
    assign popOk    = !StackEmpty && (spInc <= initWide);

    always_comb begin
        spNext  = SpOutput;
        ovfNext = SpOverflow;
        udfNext = SpUnderflow;
        // Clear first so a fault raised in the same cycle wins.
        if (FaultClr) begin
            ovfNext = 1'b0;
            udfNext = 1'b0;
        end
        case (SpOp)
            SP_PUSH: begin
                if (!StackFull) spNext  = spDec[DW-1:0];
                else            ovfNext = 1'b1;
            end
            SP_POP: begin
                if (popOk) spNext  = spInc[DW-1:0];
                else       udfNext = 1'b1;
            end
            SP_LOAD: spNext = ALU;
            SP_HOLD: spNext = SpOutput;
            default: spNext = SpOutput;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            SpOutput    <= SP_INIT;
            SpOverflow  <= 1'b0;
            SpUnderflow <= 1'b0;
        end else begin
            SpOutput    <= spNext;
            SpOverflow  <= ovfNext;
            SpUnderflow <= udfNext;
        end
    end
`else
    logic unusedFaultClr;

    assign unusedFaultClr = FaultClr;
    assign SpOverflow     = 1'b0;
    assign SpUnderflow    = 1'b0;

    // Without bounds checking push/pop simply wrap modulo 2^DW.
    always_comb begin
        spNext = SpOutput;
        case (SpOp)
            SP_PUSH: spNext = spDec[DW-1:0];
            SP_POP:  spNext = spInc[DW-1:0];
            SP_LOAD: spNext = ALU;
            SP_HOLD: spNext = SpOutput;
            default: spNext = SpOutput;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            SpOutput <= SP_INIT;
        end else begin
            SpOutput <= spNext;
        end
    end
`endif

endmodule

// File: tb/tb_acc_sp_unit.sv
// Testbench for acc_sp_unit: directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model of the unit.
module tb_acc_sp_unit;

    localparam int DW    = 16;
    localparam int INIT  = 'h0400;
    localparam int LIMIT = 'h03F0;
    localparam int STEP  = 2;

`ifdef ACC_SP_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  IR;
    logic [15:0] MemData, MDR, ALU;
    logic [2:0]  AccSrc;
    logic        AccWrite;
    logic [1:0]  SpOp;
    logic        FaultClr;
    logic [15:0] AccOutput, SpOutput, SE, SELeft, ZE;
    logic        StackEmpty, StackFull, SpOverflow, SpUnderflow;

    acc_sp_unit dut (
        .CLK(CLK), .reset(reset), .IR(IR), .MemData(MemData), .MDR(MDR),
        .ALU(ALU), .AccSrc(AccSrc), .AccWrite(AccWrite), .SpOp(SpOp),
        .FaultClr(FaultClr), .AccOutput(AccOutput), .SpOutput(SpOutput),
        .SE(SE), .SELeft(SELeft), .ZE(ZE), .StackEmpty(StackEmpty),
        .StackFull(StackFull), .SpOverflow(SpOverflow), .SpUnderflow(SpUnderflow)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chkEn = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mAcc, mSp;
    logic        mOvf, mUdf;

    function automatic logic [15:0] expSE(input logic [7:0] ir);
        int v;
        v = int'(ir);
        if (v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    function automatic bit expFull(input logic [15:0] sp);
        return (int'(sp) - STEP) < LIMIT;
    endfunction

    function automatic bit expEmpty(input logic [15:0] sp);
        return int'(sp) == INIT;
    endfunction

    function automatic bit expPopOk(input logic [15:0] sp);
        return (int'(sp) != INIT) && (int'(sp) + STEP <= INIT);
    endfunction

    function automatic logic [15:0] accValue(input logic [2:0] src, input logic [7:0] ir,
                                             input logic [15:0] mem, input logic [15:0] mdr,
                                             input logic [15:0] alu, input logic [15:0] acc);
        case (src)
            3'd0:    return 16'(int'(ir) * 256);
            3'd1:    return mdr;
            3'd2:    return mem;
            3'd3:    return expSE(ir);
            3'd4:    return alu;
            3'd5:    return 16'(int'(ir));
            3'd6:    return 16'(int'(acc) - (int'(acc) % 256) + int'(ir));
            default: return acc;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (reset) begin
            mAcc = 16'(0);
            mSp  = 16'(INIT);
            mOvf = 1'b0;
            mUdf = 1'b0;
        end else begin
            if (AccWrite) mAcc = accValue(AccSrc, IR, MemData, MDR, ALU, mAcc);
            if (BOUNDS && FaultClr) begin
                mOvf = 1'b0;
                mUdf = 1'b0;
            end
            case (SpOp)
                2'b01: begin
                    if (BOUNDS && expFull(mSp)) mOvf = 1'b1;
                    else                        mSp  = 16'(int'(mSp) - STEP);
                end
                2'b10: begin
                    if (BOUNDS && !expPopOk(mSp)) mUdf = 1'b1;
                    else                          mSp  = 16'(int'(mSp) + STEP);
                end
                2'b11: mSp = ALU;
                default: ;
            endcase
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge CLK) begin
        if (chkEn) begin
            check("AccOutput",   AccOutput,   mAcc);
            check("SpOutput",    SpOutput,    mSp);
            check("SE",          SE,          expSE(IR));
            check("SELeft",      SELeft,      16'(int'(expSE(IR)) * 2));
            check("ZE",          ZE,          16'(int'(IR)));
            check("StackEmpty",  16'(StackEmpty),  16'(expEmpty(mSp)));
            check("StackFull",   16'(StackFull),   16'(expFull(mSp)));
            check("SpOverflow",  16'(SpOverflow),  16'(mOvf));
            check("SpUnderflow", 16'(SpUnderflow), 16'(mUdf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        AccWrite = 1'b0;
        SpOp     = 2'b00;
        FaultClr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; IR = '0; MemData = '0; MDR = '0; ALU = '0;
        AccSrc = '0; AccWrite = 1'b0; SpOp = '0; FaultClr = 1'b0;
        tick();
        chkEn = 1'b1;

        // Reset state
        check("rst_acc",   AccOutput, 16'h0000);
        check("rst_sp",    SpOutput,  16'h0400);
        check("rst_empty", 16'(StackEmpty),  16'd1);
        check("rst_ovf",   16'(SpOverflow),  16'd0);
        check("rst_udf",   16'(SpUnderflow), 16'd0);

        // Two-instruction constant load
        reset = 1'b0;
        IR = 8'h12; AccSrc = 3'd0; AccWrite = 1'b1;
        tick();
        check("upper_imm", AccOutput, 16'h1200);
        IR = 8'h34; AccSrc = 3'd6;
        tick();
        check("lower_fill", AccOutput, 16'h1234);

        // Immediate forms with negative IR
        AccWrite = 1'b0; IR = 8'h80;
        #1;
        check("se_80",     SE,     16'hFF80);
        check("seleft_80", SELeft, 16'hFF00);
        check("ze_80",     ZE,     16'h0080);
        AccSrc = 3'd3; AccWrite = 1'b1;
        tick();
        check("acc_se", AccOutput, 16'hFF80);
        idle();

        // Fill the stack, then one push too many
        reset = 1'b1; tick(); reset = 1'b0;
        SpOp = 2'b01;
        repeat (8) tick();
        check("sp_full",   SpOutput, 16'h03F0);
        check("full_flag", 16'(StackFull), 16'd1);
        tick();
        check("sp_9th",  SpOutput, BOUNDS ? 16'h03F0 : 16'h03EE);
        check("ovf_9th", 16'(SpOverflow), BOUNDS ? 16'd1 : 16'd0);
        idle();

        // Underflow and fault clear interaction
        reset = 1'b1; tick(); reset = 1'b0;
        SpOp = 2'b10;
        tick();
        check("sp_pop_empty", SpOutput, BOUNDS ? 16'h0400 : 16'h0402);
        check("udf_set", 16'(SpUnderflow), BOUNDS ? 16'd1 : 16'd0);
        FaultClr = 1'b1;
        tick();
        check("udf_clr_vs_fault", 16'(SpUnderflow), BOUNDS ? 16'd1 : 16'd0);
        SpOp = 2'b00;
        tick();
        check("udf_clr", 16'(SpUnderflow), 16'd0);
        idle();

        // SP load and accumulator write in the same cycle, then reset with push
        reset = 1'b1; tick(); reset = 1'b0;
        SpOp = 2'b11; ALU = 16'h0200; AccSrc = 3'd4; AccWrite = 1'b1;
        tick();
        check("sp_load",   SpOutput,  16'h0200);
        check("acc_alu",   AccOutput, 16'h0200);
        check("load_ovf",  16'(SpOverflow),  16'd0);
        check("load_udf",  16'(SpUnderflow), 16'd0);
        reset = 1'b1; SpOp = 2'b01;
        tick();
        check("rst_dominates", SpOutput, 16'h0400);
        reset = 1'b0;
        idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            reset   = ($urandom_range(0, 99) == 0);
            IR      = 8'($urandom);
            MemData = 16'($urandom);
            MDR     = 16'($urandom);
            r = $urandom_range(0, 3);
            case (r)
                0:       ALU = 16'($urandom);
                1:       ALU = 16'(LIMIT - 4 + 2 * $urandom_range(0, 12));
                2:       ALU = 16'($urandom_range(0, 5));
                default: ALU = 16'(INIT - 5 + $urandom_range(0, 10));
            endcase
            AccSrc   = 3'($urandom);
            AccWrite = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 19);
            if (r < 8)       SpOp = 2'b01;
            else if (r < 16) SpOp = 2'b10;
            else if (r < 18) SpOp = 2'b11;
            else             SpOp = 2'b00;
            FaultClr = ($urandom_range(0, 7) == 0);
            tick();
        end

        idle();
        reset = 1'b0;
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_sp_unit.md
Name: acc_sp_unit

Overview:
Parametrised accumulator and stack-pointer register unit for the accumulator datapath.
- Generates the sign-extended, shifted, zero-extended and upper-placed forms of the instruction immediate.
- Selects and registers the accumulator source.
- Owns a self-incrementing and decrementing stack pointer with bounds checking and sticky fault flags, so SP push/pop no longer needs an ALU pass.
- Sits between the instruction register/memory interface and the ALU.

Parameters:
- DW, 16, datapath width; legal range DW >= IW+1.
- IW, 8, immediate field width taken from IR.
- SP_INIT, 16'h0400, SP reset value and empty-stack address (top, exclusive).
- SP_LIMIT, 16'h03F0, lowest legal SP value (full-stack address).
- STEP, 2, SP adjustment per push/pop (bytes per word).

Ports:
- CLK  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- IR  input  IW  immediate field
- MemData  input  DW  memory read data
- MDR  input  DW  memory data register
- ALU  input  DW  ALU result
- AccSrc  input  3  accumulator source select
- AccWrite  input  1  accumulator write enable
- SpOp  input  2  00 hold, 01 push (SP -= STEP), 10 pop (SP += STEP), 11 load SP from ALU
- FaultClr  input  1  clears sticky fault flags
- AccOutput  output  DW  accumulator register
- SpOutput  output  DW  stack-pointer register
- SE  output  DW  sign-extended IR
- SELeft  output  DW  SE << 1, truncated to DW
- ZE  output  DW  zero-extended IR
- StackEmpty  output  1  SP == SP_INIT
- StackFull  output  1  SP - STEP < SP_LIMIT (unsigned, computed DW+1 wide)
- SpOverflow  output  1  sticky: push refused
- SpUnderflow  output  1  sticky: pop refused

Behaviour:
- Reset (synchronous, dominates all other inputs): AccOutput=0, SpOutput=SP_INIT, SpOverflow=0, SpUnderflow=0.
- SE, SELeft, ZE, StackEmpty and StackFull are combinational; zero latency.
- AccSrc encoding:
  - 0: IR << (DW-IW) (upper immediate)
  - 1: MDR
  - 2: MemData
  - 3: SE
  - 4: ALU
  - 5: ZE
  - 6: AccOutput[DW-1:IW] concatenated with IR (lower-fill; completes a two-instruction constant load after source 0)
  - 7: AccOutput (hold)
- Accumulator loads the selected value on the rising edge when AccWrite=1; otherwise it holds. One-cycle latency.
- SP push (01):
  - If StackFull=0: SP <= SP - STEP.
  - Else: SP holds and SpOverflow <= 1.
- SP pop (10):
  - If StackEmpty=0 and SP + STEP <= SP_INIT: SP <= SP + STEP.
  - Else: SP holds and SpUnderflow <= 1.
- SP load (11): SP <= ALU unconditionally. No bounds check; no flag change.
- Bounds arithmetic is done DW+1 bits wide, so SP never wraps modulo 2^DW via push/pop.
- Accumulator and SP updates are independent; both may occur in the same cycle.
- FaultClr=1 clears both flags. If a fault occurs in the same cycle, the new fault wins and that flag reads 1 next cycle.
- Reset asserted mid-sequence (e.g. between AccSrc 0 and 6) discards the partial constant. No residual state.

Optional Feature:
ACC_SP_BOUNDS_CHECK_EN
- Defined: push/pop bounds checking, refusal and sticky flags as above.
- Undefined:
  - Push/pop always adjust SP modulo 2^DW.
  - SpOverflow and SpUnderflow are tied 0.
  - StackEmpty and StackFull remain as combinational compares.
  - FaultClr is ignored.

Test Plan:
- Reset -> AccOutput=0x0000, SpOutput=0x0400, StackEmpty=1, both flags 0.
- IR=0x12, AccSrc=0, AccWrite=1, then IR=0x34, AccSrc=6, AccWrite=1 -> AccOutput=0x1200, then 0x1234.
- IR=0x80 -> SE=0xFF80, SELeft=0xFF00, ZE=0x0080; AccSrc=3 write -> AccOutput=0xFF80.
- 8 pushes from reset -> SpOutput=0x03F0, StackFull=1. 9th push -> SP stays 0x03F0, SpOverflow=1 next cycle. Macro undefined: SP=0x03EE, flag 0.
- Pop at reset value -> SP stays 0x0400, SpUnderflow=1. Same cycle as an underflowing pop, FaultClr=1 -> SpUnderflow stays 1. FaultClr alone -> 0.
- SpOp=11, ALU=0x0200, with AccSrc=4, AccWrite=1 in the same cycle -> SpOutput=0x0200, AccOutput=0x0200, no flags. Reset asserted with SpOp=01 -> SpOutput=0x0400.
